tx_scheduler: RTL and testbench
===============================

# tx_scheduler

Round-robin transmit scheduler that shares the single UDP/IP/Ethernet transmit path of `network_stack` between `NREQ` payload requesters. It grants one requester at a time and streams that requester's words into the stack's payload port. It drives the per-frame destination IP and UDP ports, then triggers the launch by dropping `axiiv`. It tracks the frame on `eth_txen` and enforces the inter-packet gap before the next grant.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `DATA_SIZE`, 16: payload word width.
- `MAX_WORDS`, 736: maximum words per frame (1472 bytes at 16 bits).
- `IPG_CYCLES`, 48: idle cycles after `eth_txen` falls (96 bit times at N=2).
- `WDOG_CYCLES`, 4096: watchdog limit, used only with `TX_SCHED_WDOG_EN`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  requester i has a word.
- `req_data`  in  NREQ*DATA_SIZE  word of requester i, in slice i.
- `req_last`  in  NREQ  word is the last of the frame.
- `req_dst_ip`  in  NREQ*32  destination IP of requester i.
- `req_src_port`, `req_dst_port`  in  NREQ*16  UDP ports of requester i.
- `req_ready`  out  NREQ  word of requester i is accepted this cycle.
- `stk_axiiv`  out  1  to stack `axiiv`.
- `stk_axiid`  out  DATA_SIZE  to stack `axiid`.
- `stk_dst_ip`  out  32  to stack `dst_ip_in`.
- `stk_udp_src_port`, `stk_udp_dst_port`  out  16  to the stack's UDP port inputs.
- `eth_txen`  in  1  stack transmit enable (feedback).
- `grant_id`  out  clog2(NREQ)  current grantee.
- `busy`  out  1  the state is not IDLE.
- `done_pulse`  out  1  one-cycle pulse when the gap completes.
- `err_overflow`  out  1  one-cycle pulse when the frame is truncated at `MAX_WORDS`.
- `err_underrun`  out  1  one-cycle pulse when `req_valid` drops before `req_last`.
- `err_timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, LOAD, DRAIN, LAUNCH, SEND, GAP.
- IDLE
  - If any `req_valid` is set, pick the first set bit at or after pointer `rr_ptr`, wrapping modulo NREQ.
  - Register `grant_id` and latch that requester's IP and ports into the `stk_*` config registers.
  - Go to LOAD.
- LOAD
  - `req_ready[grant_id]` = `req_valid[grant_id]`; all other ready bits are 0.
  - Each handshake increments `word_cnt` (16 bits).
  - Handshake with `req_last` set: go to LAUNCH.
  - Handshake that brings `word_cnt` to `MAX_WORDS` without `req_last`: pulse `err_overflow`, go to DRAIN.
  - `req_valid[grant_id]` low for a cycle after at least one word: pulse `err_underrun`, go to LAUNCH. A bubble would be seen by the stack as a launch edge, so the frame ends here.
- DRAIN
  - `req_ready[grant_id]` = 1 and `stk_axiiv` = 0; incoming words are discarded.
  - Exit to LAUNCH on a handshake with `req_last`.
- LAUNCH: wait for `eth_txen` = 1, then go to SEND.
- SEND: wait for `eth_txen` = 0, then go to GAP.
- GAP
  - Count `IPG_CYCLES` cycles.
  - Then pulse `done_pulse`, set `rr_ptr` = (`grant_id`+1) mod NREQ, and go to IDLE.
- The config outputs hold their values from grant until IDLE is re-entered; they are never changed mid-frame.

## Timing
- Reset values:
  - All outputs are 0: `stk_*`, `req_ready`, `grant_id`, `busy`, and all pulses.
  - State is IDLE, `rr_ptr` = 0, all counters are 0.
- Reset mid-frame: everything clears immediately. The resulting `stk_axiiv` fall is harmless because the stack shares the same reset.
- Grant latency: `req_valid` seen in IDLE at cycle t; `req_ready` can assert from cycle t+1.
- Data path: a word accepted at cycle k appears on `stk_axiid` with `stk_axiiv` = 1 at cycle k+1 (registered).
- Launch edge: `stk_axiiv` is 0 in the cycle after the final accepted word and stays 0 until the next LOAD.
- `done_pulse` occurs at the earliest `IPG_CYCLES` cycles after `eth_txen` falls.
- Requests that arrive during LOAD through GAP wait; no preemption.
- Simultaneous requests are granted in strict rotation.
- A one-word frame (`req_last` on the first word) is legal.

## Configuration
- `TX_SCHED_WDOG_EN` defined:
  - A 16-bit watchdog counts the cycles spent in LAUNCH plus SEND.
  - On reaching `WDOG_CYCLES` it pulses `err_timeout` and forces GAP.
- Not defined: the counter is not built, `err_timeout` is tied to 0, and LAUNCH/SEND wait indefinitely.

## Structure
- Package `tx_sched_pkg` holds:
  - the state enum `tx_sched_state_t`;
  - the default constants `TX_SCHED_IPG_CYCLES` and `TX_SCHED_MAX_WORDS`.
- Sub-module `rr_arbiter`:
  - combinational first-set-bit-from-pointer select over NREQ;
  - outputs a one-hot grant plus the index;
  - instantiated once.

## Test plan
- **Single frame:** requester 0 sends 3 words 0x1111, 0x2222, 0x3333 (last on the third), `eth_txen` is modelled high 10 cycles later for 20 cycles.
  - `stk_axiid` carries those values on consecutive cycles, then `stk_axiiv` falls.
  - `done_pulse` fires 48 cycles after `eth_txen` falls.
- **Rotation:** all 4 requesters hold `req_valid` with 1-word frames → grant order is 0, 1, 2, 3, 0.
- **Config latch:** requester 2 has dst_ip 0x0A000002 and ports 5000/6000 → `stk_*` shows these values from grant through GAP, unchanged while the other requesters' inputs toggle.
- **Overflow:** with `MAX_WORDS` = 4, send a 6-word frame.
  - Exactly 4 words are forwarded and `err_overflow` pulses once.
  - Words 5 and 6 are drained; the next grant goes to the next requester.
- **Underrun and reset:**
  - A bubble after word 2 → `err_underrun` pulses and the launch follows the bubble.
  - Asserting `rst` low mid-LOAD → all outputs are 0 in the same cycle and state is IDLE with `rr_ptr` = 0.
- **Watchdog (`TX_SCHED_WDOG_EN`):** `eth_txen` held at 0 after launch → `err_timeout` pulses after 4096 cycles, then GAP, then IDLE.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types and default constants for the round-robin transmit scheduler.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    LAUNCH,
    SEND,
    GAP
  } tx_sched_state_t;

  localparam int TX_SCHED_IPG_CYCLES = 48;
  localparam int TX_SCHED_MAX_WORDS  = 736;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set request bit at or after the
// pointer, wrapping modulo NREQ. Returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  int   cand;
  logic found;

  always_comb begin
    // NOTE: every output and local gets a default first, so no path through
    // the loop can leave one unassigned and infer a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NREQ; off++) begin
      cand = (int'(ptr_i) + off) % NREQ;
      if (!found && req_i[IW'(cand)]) begin
        found              = 1'b1;
        gnt_o[IW'(cand)]   = 1'b1;
        idx_o              = IW'(cand);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin transmit scheduler feeding one UDP/IP/Ethernet stack from NREQ
// requesters. Define TX_SCHED_WDOG_EN to build the LAUNCH/SEND watchdog.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DATA_SIZE   = 16,
  parameter int MAX_WORDS   = TX_SCHED_MAX_WORDS,
  parameter int IPG_CYCLES  = TX_SCHED_IPG_CYCLES,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DATA_SIZE-1:0] req_data,
  input  logic [NREQ-1:0]           req_last,
  input  logic [NREQ*32-1:0]        req_dst_ip,
  input  logic [NREQ*16-1:0]        req_src_port,
  input  logic [NREQ*16-1:0]        req_dst_port,
  output logic [NREQ-1:0]           req_ready,
  output logic                      stk_axiiv,
  output logic [DATA_SIZE-1:0]      stk_axiid,
  output logic [31:0]               stk_dst_ip,
  output logic [15:0]               stk_udp_src_port,
  output logic [15:0]               stk_udp_dst_port,
  input  logic                      eth_txen,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      done_pulse,
  output logic                      err_overflow,
  output logic                      err_underrun,
  output logic                      err_timeout
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_WORDS < 1 || MAX_WORDS > 65535 ||
      IPG_CYCLES < 1 || IPG_CYCLES > 65535 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_params
    $error("tx_scheduler: parameter out of range");
  end

  tx_sched_state_t      state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d, rr_ptr_q, rr_ptr_d, arb_idx;
  logic [NREQ-1:0]      grant_oh_q, grant_oh_d, arb_gnt;
  logic                 arb_any;
  logic [15:0]          word_cnt_q, word_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [DATA_SIZE-1:0] axiid_q, axiid_d;
  logic                 axiiv_q, axiiv_d;
  logic [31:0]          dst_ip_q, dst_ip_d;
  logic [15:0]          src_port_q, src_port_d, dst_port_q, dst_port_d;
  logic                 done_q, done_d, ovf_q, ovf_d, und_q, und_d;

  logic                 sel_valid, sel_last;
  logic [DATA_SIZE-1:0] sel_data;

  assign sel_valid = |(req_valid & grant_oh_q);
  assign sel_last  = |(req_last & grant_oh_q);
  assign sel_data  = req_data[int'(grant_q)*DATA_SIZE +: DATA_SIZE];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

`ifdef TX_SCHED_WDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    axiid_d    = axiid_q;
    axiiv_d    = 1'b0;
    dst_ip_d   = dst_ip_q;
    src_port_d = src_port_q;
    dst_port_d = dst_port_q;
    done_d     = 1'b0;
    ovf_d      = 1'b0;
    und_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_gnt;
          dst_ip_d   = req_dst_ip[int'(arb_idx)*32 +: 32];
          src_port_d = req_src_port[int'(arb_idx)*16 +: 16];
          dst_port_d = req_dst_port[int'(arb_idx)*16 +: 16];
          word_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (sel_valid) begin
          word_cnt_d = word_cnt_q + 16'd1;
          axiid_d    = sel_data;
          axiiv_d    = 1'b1;
          if (sel_last) begin
            state_d = LAUNCH;
          end else if (word_cnt_d == 16'(MAX_WORDS)) begin
            ovf_d   = 1'b1;
            state_d = DRAIN;
          end
        end else if (word_cnt_q != '0) begin
          // Any bubble would read as a launch edge at the stack, so end the frame now.
          und_d   = 1'b1;
          state_d = LAUNCH;
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (eth_txen) state_d = SEND;
      end
      SEND: begin
        // The cycle in which eth_txen is first seen low is the first gap cycle.
        if (!eth_txen) begin
          state_d   = GAP;
          gap_cnt_d = 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q >= 16'(IPG_CYCLES - 1)) begin
          done_d    = 1'b1;
          gap_cnt_d = '0;
          rr_ptr_d  = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TX_SCHED_WDOG_EN
    wdog_cnt_d = '0;
    tmo_d      = 1'b0;
    if (state_q == LAUNCH || state_q == SEND) begin
      if (wdog_cnt_q == 16'(WDOG_CYCLES - 1)) begin
        tmo_d     = 1'b1;
        state_d   = GAP;
        gap_cnt_d = 16'd1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      axiid_q    <= '0;
      axiiv_q    <= 1'b0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      axiid_q    <= axiid_d;
      axiiv_q    <= axiiv_d;
      dst_ip_q   <= dst_ip_d;
      src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      und_q      <= und_d;
    end
  end

`ifdef TX_SCHED_WDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      tmo_q      <= tmo_d;
    end
  end
  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    req_ready = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      LOAD:    req_ready = req_valid & grant_oh_q;
      DRAIN:   req_ready = grant_oh_q;
      default: req_ready = '0;
    endcase
  end

  assign stk_axiiv        = axiiv_q;
  assign stk_axiid        = axiid_q;
  assign stk_dst_ip       = dst_ip_q;
  assign stk_udp_src_port = src_port_q;
  assign stk_udp_dst_port = dst_port_q;
  assign grant_id         = grant_q;
  assign done_pulse       = done_q;
  assign err_overflow     = ovf_q;
  assign err_underrun     = und_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed self-checking bench for tx_scheduler (MAX_WORDS reduced to 4).
module tb_tx_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*32-1:0]   req_dst_ip;
  logic [NREQ*16-1:0]   req_src_port, req_dst_port;
  logic                 stk_axiiv;
  logic [DW-1:0]        stk_axiid;
  logic [31:0]          stk_dst_ip;
  logic [15:0]          stk_udp_src_port, stk_udp_dst_port;
  logic                 eth_txen;
  logic [1:0]           grant_id;
  logic                 busy, done_pulse, err_overflow, err_underrun, err_timeout;

  int total = 0;
  int bad   = 0;

  tx_scheduler #(
    .NREQ(NREQ), .DATA_SIZE(DW), .MAX_WORDS(4), .IPG_CYCLES(48), .WDOG_CYCLES(4096)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_dst_ip(req_dst_ip), .req_src_port(req_src_port), .req_dst_port(req_dst_port),
    .req_ready(req_ready),
    .stk_axiiv(stk_axiiv), .stk_axiid(stk_axiid), .stk_dst_ip(stk_dst_ip),
    .stk_udp_src_port(stk_udp_src_port), .stk_udp_dst_port(stk_udp_dst_port),
    .eth_txen(eth_txen), .grant_id(grant_id), .busy(busy), .done_pulse(done_pulse),
    .err_overflow(err_overflow), .err_underrun(err_underrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [15:0] d, input logic l);
    req_valid[r]        = v;
    req_data[r*DW +: DW] = d;
    req_last[r]         = l;
  endtask

  task automatic toggle_cfg();
    req_dst_ip   = ~req_dst_ip;
    req_src_port = ~req_src_port;
    req_dst_port = ~req_dst_port;
  endtask

  task automatic launch_txen();
    repeat (3) tick();
    eth_txen = 1'b1;
    repeat (5) tick();
    eth_txen = 1'b0;
  endtask

  // Returns the number of clocks until done_pulse is seen, or -1 on timeout.
  task automatic wait_done(output int n);
    int k;
    k = 0;
    n = -1;
    while (n < 0 && k < 300) begin
      tick();
      k++;
      if (done_pulse === 1'b1) n = k;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = '1;
    repeat (2) tick();
    total++;
    if ({stk_axiiv, stk_axiid, stk_dst_ip, stk_udp_src_port, stk_udp_dst_port} !== '0) begin
      bad++;
      $display("FAIL reset_stk: got %h want 0", {stk_axiiv, stk_axiid, stk_dst_ip, stk_udp_src_port, stk_udp_dst_port});
    end
    total++;
    if ({req_ready, grant_id, busy} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b grant=%0d busy=%b want 0", req_ready, grant_id, busy);
    end
    total++;
    if ({done_pulse, err_overflow, err_underrun, err_timeout} !== 4'd0) begin
      bad++;
      $display("FAIL reset_pulses: got %b want 0000", {done_pulse, err_overflow, err_underrun, err_timeout});
    end
    req_valid = '0;
    #3 rst = 1'b1;
  endtask

  task automatic test_single_frame();
    int hi;
    int n;
    set_req(0, 1'b1, 16'h1111, 1'b0);
    tick();
    total++;
    if ({busy, grant_id, req_ready} !== {1'b1, 2'd0, 4'b0001}) begin
      bad++;
      $display("FAIL sf_grant: busy=%b grant=%0d ready=%b want 1/0/0001", busy, grant_id, req_ready);
    end
    tick();
    total++;
    if ({stk_axiiv, stk_axiid} !== {1'b1, 16'h1111}) begin
      bad++;
      $display("FAIL sf_word1: got %h want %h", {stk_axiiv, stk_axiid}, {1'b1, 16'h1111});
    end
    set_req(0, 1'b1, 16'h2222, 1'b0);
    tick();
    total++;
    if ({stk_axiiv, stk_axiid} !== {1'b1, 16'h2222}) begin
      bad++;
      $display("FAIL sf_word2: got %h want %h", {stk_axiiv, stk_axiid}, {1'b1, 16'h2222});
    end
    set_req(0, 1'b1, 16'h3333, 1'b1);
    tick();
    total++;
    if ({stk_axiiv, stk_axiid} !== {1'b1, 16'h3333}) begin
      bad++;
      $display("FAIL sf_word3: got %h want %h", {stk_axiiv, stk_axiid}, {1'b1, 16'h3333});
    end
    set_req(0, 1'b0, 16'h0000, 1'b0);
    tick();
    total++;
    if ({stk_axiiv, busy} !== 2'b01) begin
      bad++;
      $display("FAIL sf_launch_edge: axiiv=%b busy=%b want 0/1", stk_axiiv, busy);
    end
    hi = 0;
    repeat (8) begin tick(); if (stk_axiiv !== 1'b0) hi++; end
    eth_txen = 1'b1;
    repeat (20) begin tick(); if (stk_axiiv !== 1'b0) hi++; end
    eth_txen = 1'b0;
    total++;
    if (hi !== 0) begin
      bad++;
      $display("FAIL sf_axiiv_low: got %0d high cycles want 0", hi);
    end
    wait_done(n);
    total++;
    if (n !== 48) begin
      bad++;
      $display("FAIL sf_ipg: got %0d cycles want 48", n);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL sf_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_rotation();
    int w;
    int n;
    int exp;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(16'h00A0 + i), 1'b1);
    for (int k = 0; k < 5; k++) begin
      exp = k % NREQ;
      w = 0;
      while (busy !== 1'b1 && w < 10) begin tick(); w++; end
      total++;
      if ({grant_id, req_ready} !== {2'(exp), 4'(1 << exp)}) begin
        bad++;
        $display("FAIL rot_grant%0d: grant=%0d ready=%b want %0d", k, grant_id, req_ready, exp);
      end
      tick();
      total++;
      if ({stk_axiiv, stk_axiid} !== {1'b1, 16'(16'h00A0 + exp)}) begin
        bad++;
        $display("FAIL rot_data%0d: got %h want %h", k, {stk_axiiv, stk_axiid}, {1'b1, 16'(16'h00A0 + exp)});
      end
      launch_txen();
      wait_done(n);
      total++;
      if (n !== 48) begin
        bad++;
        $display("FAIL rot_done%0d: got %0d want 48", k, n);
      end
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_config_latch();
    logic [63:0] exp_cfg;
    int hold_bad;
    int cyc;
    logic seen;
    exp_cfg = {32'h0A00_0002, 16'd5000, 16'd6000};
    req_dst_ip[2*32 +: 32]   = 32'h0A00_0002;
    req_src_port[2*16 +: 16] = 16'd5000;
    req_dst_port[2*16 +: 16] = 16'd6000;
    set_req(2, 1'b1, 16'h2001, 1'b0);
    tick();
    total++;
    if ({grant_id, stk_dst_ip, stk_udp_src_port, stk_udp_dst_port} !== {2'd2, exp_cfg}) begin
      bad++;
      $display("FAIL cfg_grant: grant=%0d cfg=%h want 2 %h", grant_id, {stk_dst_ip, stk_udp_src_port, stk_udp_dst_port}, exp_cfg);
    end
    hold_bad = 0;
    toggle_cfg();
    tick();
    if ({stk_dst_ip, stk_udp_src_port, stk_udp_dst_port} !== exp_cfg) hold_bad++;
    set_req(2, 1'b1, 16'h2002, 1'b1);
    toggle_cfg();
    tick();
    if ({stk_dst_ip, stk_udp_src_port, stk_udp_dst_port} !== exp_cfg) hold_bad++;
    set_req(2, 1'b0, 16'h0000, 1'b0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      eth_txen = (cyc >= 3 && cyc < 8);
      toggle_cfg();
      tick();
      cyc++;
      if ({stk_dst_ip, stk_udp_src_port, stk_udp_dst_port} !== exp_cfg) hold_bad++;
      if (done_pulse === 1'b1) seen = 1'b1;
    end
    eth_txen = 1'b0;
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL cfg_done: done_pulse seen=%b want 1", seen);
    end
    total++;
    if (hold_bad !== 0) begin
      bad++;
      $display("FAIL cfg_hold: got %0d changed cycles want 0", hold_bad);
    end
  endtask

  task automatic test_overflow();
    int fwd;
    int ovf;
    int data_bad;
    int n;
    set_req(3, 1'b1, 16'h3001, 1'b0);
    set_req(0, 1'b1, 16'h0BAD, 1'b1);
    tick();
    total++;
    if (grant_id !== 2'd3) begin
      bad++;
      $display("FAIL ovf_grant: got %0d want 3", grant_id);
    end
    fwd = 0; ovf = 0; data_bad = 0;
    for (int w = 1; w <= 6; w++) begin
      set_req(3, 1'b1, 16'(16'h3000 + w), (w == 6));
      tick();
      if (stk_axiiv === 1'b1) begin
        fwd++;
        if (stk_axiid !== 16'(16'h3000 + fwd)) data_bad++;
      end
      if (err_overflow === 1'b1) ovf++;
      if (w == 4) begin
        total++;
        if (req_ready !== 4'b1000) begin
          bad++;
          $display("FAIL ovf_drain_ready: got %b want 1000", req_ready);
        end
      end
    end
    set_req(3, 1'b0, 16'h0000, 1'b0);
    repeat (3) begin
      tick();
      if (stk_axiiv === 1'b1) fwd++;
      if (err_overflow === 1'b1) ovf++;
    end
    total++;
    if (fwd !== 4) begin
      bad++;
      $display("FAIL ovf_forwarded: got %0d words want 4", fwd);
    end
    total++;
    if (ovf !== 1) begin
      bad++;
      $display("FAIL ovf_pulses: got %0d want 1", ovf);
    end
    total++;
    if (data_bad !== 0) begin
      bad++;
      $display("FAIL ovf_data: got %0d bad words want 0", data_bad);
    end
    launch_txen();
    wait_done(n);
    tick();
    total++;
    if ({busy, grant_id} !== {1'b1, 2'd0}) begin
      bad++;
      $display("FAIL ovf_next_grant: busy=%b grant=%0d want 1/0", busy, grant_id);
    end
    tick();
    set_req(0, 1'b0, 16'h0000, 1'b0);
    launch_txen();
    wait_done(n);
  endtask

  task automatic test_underrun();
    int n;
    set_req(1, 1'b1, 16'h4001, 1'b0);
    tick();
    total++;
    if (grant_id !== 2'd1) begin
      bad++;
      $display("FAIL und_grant: got %0d want 1", grant_id);
    end
    tick();
    set_req(1, 1'b1, 16'h4002, 1'b0);
    tick();
    total++;
    if ({stk_axiiv, stk_axiid} !== {1'b1, 16'h4002}) begin
      bad++;
      $display("FAIL und_word2: got %h want %h", {stk_axiiv, stk_axiid}, {1'b1, 16'h4002});
    end
    set_req(1, 1'b0, 16'h0000, 1'b0);
    tick();
    total++;
    if ({err_underrun, stk_axiiv} !== 2'b10) begin
      bad++;
      $display("FAIL und_pulse: underrun=%b axiiv=%b want 1/0", err_underrun, stk_axiiv);
    end
    set_req(1, 1'b1, 16'h4003, 1'b0);
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL und_no_ready: got %b want 0000", req_ready);
    end
    tick();
    total++;
    if ({err_underrun, stk_axiiv} !== 2'b00) begin
      bad++;
      $display("FAIL und_one_cycle: underrun=%b axiiv=%b want 0/0", err_underrun, stk_axiiv);
    end
    set_req(1, 1'b0, 16'h0000, 1'b0);
    launch_txen();
    wait_done(n);
    total++;
    if (n !== 48) begin
      bad++;
      $display("FAIL und_done: got %0d want 48", n);
    end
  endtask

  task automatic test_reset_mid_load();
    int n;
    set_req(2, 1'b1, 16'h5001, 1'b0);
    tick();
    tick();
    total++;
    if ({busy, stk_axiiv, grant_id} !== {1'b1, 1'b1, 2'd2}) begin
      bad++;
      $display("FAIL rml_pre: busy=%b axiiv=%b grant=%0d want 1/1/2", busy, stk_axiiv, grant_id);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({stk_axiiv, stk_axiid, stk_dst_ip, stk_udp_src_port, stk_udp_dst_port} !== '0) begin
      bad++;
      $display("FAIL rml_stk: got %h want 0", {stk_axiiv, stk_axiid, stk_dst_ip, stk_udp_src_port, stk_udp_dst_port});
    end
    total++;
    if ({req_ready, grant_id, busy, done_pulse, err_overflow, err_underrun, err_timeout} !== 11'd0) begin
      bad++;
      $display("FAIL rml_ctrl: ready=%b grant=%0d busy=%b want 0", req_ready, grant_id, busy);
    end
    #2 rst = 1'b1;
    set_req(2, 1'b0, 16'h0000, 1'b0);
    set_req(1, 1'b1, 16'h6001, 1'b1);
    set_req(3, 1'b1, 16'h7001, 1'b1);
    tick();
    total++;
    if (grant_id !== 2'd1) begin
      bad++;
      $display("FAIL rml_ptr: grant=%0d want 1", grant_id);
    end
    tick();
    set_req(1, 1'b0, 16'h0000, 1'b0);
    set_req(3, 1'b0, 16'h0000, 1'b0);
    launch_txen();
    wait_done(n);
  endtask

`ifdef TX_SCHED_WDOG_EN
  task automatic test_watchdog();
    int n;
    int m;
    logic seen;
    set_req(2, 1'b1, 16'h8001, 1'b1);
    tick();
    tick();
    set_req(2, 1'b0, 16'h0000, 1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      tick();
      n++;
      if (err_timeout === 1'b1) seen = 1'b1;
    end
    total++;
    if (n !== 4096) begin
      bad++;
      $display("FAIL wdog_cycles: got %0d want 4096", n);
    end
    wait_done(m);
    total++;
    if ({m, busy} !== {32'd47, 1'b0}) begin
      bad++;
      $display("FAIL wdog_gap: got %0d cycles busy=%b want 47/0", m, busy);
    end
  endtask
`endif

  initial begin
    rst          = 1'b0;
    eth_txen     = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_dst_ip[i*32 +: 32]   = 32'(32'hC0A8_0000 + i);
      req_src_port[i*16 +: 16] = 16'(100 + i);
      req_dst_port[i*16 +: 16] = 16'(200 + i);
    end
    test_reset();
    test_single_frame();
    test_rotation();
    test_config_latch();
    test_overflow();
    test_underrun();
    test_reset_mid_load();
`ifdef TX_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
